// File: rtl/guess_capture.sv
// -----------------------------------------------------------------------------
// guess_capture
//   Upstream stage of the hangman game FSM. Decodes PS/2 set-2 letter make
//   codes to uppercase ASCII. Each newly accepted letter is presented on
//   `guess` with a one-cycle `check_guess` pulse. The letter is then held
//   frozen for HOLD_CYCLES cycles so the game FSM can finish its position scan.
//
// Optional feature macro: GUESS_DUP_FILTER_EN
//   defined   : letters already in `used` are rejected with a `dup` pulse.
//   undefined : every accepted letter is issued; `dup` stays 0.
//
// Ports
//   Clk          system clock
//   Reset        asynchronous, active-low reset
//   new_game     synchronous clear of mask, guess, FSM and prefix flags
//   key_code[7:0] scan-code byte from the PS/2 receiver
//   key_valid    one-cycle strobe per key_code byte
//   game_over    blocks acceptance of new guesses in IDLE
//   guess[7:0]   ASCII 'A'..'Z' of the last issued letter, 0x00 when none
//   check_guess  one-cycle pulse: start checking `guess`
//   dup          one-cycle pulse: letter typed was already used
//   used[25:0]   bit i set when letter 'A'+i has been issued this game
//   busy         high while in ISSUE or HOLD
// -----------------------------------------------------------------------------
module guess_capture #(
  parameter int HOLD_CYCLES = 32,
  parameter int CNT_W       = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        new_game,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  input  logic        game_over,
  output logic [7:0]  guess,
  output logic        check_guess,
  output logic        dup,
  output logic [25:0] used,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brk_q, brk_d;
  logic               ext_q, ext_d;
  logic [7:0]         guess_q, guess_d;
  logic [25:0]        used_q, used_d;
  logic               dup_q, dup_d;

  logic               letter_hit;
  logic [4:0]         letter_idx;
  logic               make_letter;

  // Set-2 make code -> letter index (0 = 'A').
  always_comb begin
    letter_hit = 1'b1;
    letter_idx = 5'd0;
    case (key_code)
      8'h1C: letter_idx = 5'd0;
      8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;
      8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;
      8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;
      8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;
      8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;
      8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;
      8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;
      8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;
      8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;
      8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;
      8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;
      8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;
      8'h1A: letter_idx = 5'd25;
      default: letter_hit = 1'b0;
    endcase
  end

  // A terminal byte counts as a letter press only when no break/extended
  // prefix preceded it.
  assign make_letter = key_valid && (key_code != 8'hF0) && (key_code != 8'hE0)
                       && !brk_q && !ext_q && letter_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    guess_d = guess_q;
    used_d  = used_q;
    dup_d   = 1'b0;

    // Prefix tracking runs in every state.
    if (key_valid) begin
      if (key_code == 8'hF0) begin
        brk_d = 1'b1;
      end else if (key_code == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (make_letter && !game_over) begin
`ifdef GUESS_DUP_FILTER_EN
          if (used_q[letter_idx]) begin
            dup_d = 1'b1;
          end else begin
            state_d              = ISSUE;
            guess_d              = 8'h41 + {3'b000, letter_idx};
            used_d[letter_idx]   = 1'b1;
          end
`else
          state_d            = ISSUE;
          guess_d            = 8'h41 + {3'b000, letter_idx};
          used_d[letter_idx] = 1'b1;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // new_game overrides everything decided above, including the key byte.
    if (new_game) begin
      state_d = IDLE;
      cnt_d   = '0;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
      guess_d = 8'h00;
      used_d  = '0;
      dup_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      guess_q <= 8'h00;
      used_q  <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      guess_q <= guess_d;
      used_q  <= used_d;
      dup_q   <= dup_d;
    end
  end

  assign guess       = guess_q;
  assign used        = used_q;
  assign check_guess = (state_q == ISSUE);
  assign busy        = (state_q == ISSUE) || (state_q == HOLD);
`ifdef GUESS_DUP_FILTER_EN
  assign dup         = dup_q;
`else
  assign dup         = 1'b0;
`endif

endmodule
